// File: rtl/flow_frame_sched_if.sv
// Handshake bundle between the camera writer, the reshaper and the frame scheduler.
// The master side drives the scheduler inputs; the slave side is the scheduler itself.
interface flow_frame_sched_if;
  logic       sched_en;
  logic       cam_frame_done;
  logic       cam_bank;
  logic       cam_ready;
  logic       rs_ena;
  logic       rs_wr_en;
  logic       rd_bank;
  logic       busy;
  logic       frame_done;
  logic       tmo_err;
  logic [7:0] drop_cnt;

  modport master (
    output sched_en, cam_frame_done, rs_wr_en,
    input  cam_bank, cam_ready, rs_ena, rd_bank, busy, frame_done, tmo_err, drop_cnt
  );

  modport slave (
    input  sched_en, cam_frame_done, rs_wr_en,
    output cam_bank, cam_ready, rs_ena, rd_bank, busy, frame_done, tmo_err, drop_cnt
  );
endinterface

// File: rtl/flow_frame_sched.sv
// Frame scheduler with ping-pong ownership of a two-bank source buffer: the camera fills
// one bank while the reshaper consumes the other, with frame-drop counting and a watchdog.
module flow_frame_sched #(
  parameter int OUT_WORDS = 202800,
  parameter int CNT_W     = 18,
  parameter int TIMEOUT   = 300000,
  parameter int TMO_W     = 20
) (
  input logic               clk,
  input logic               rstn,
  flow_frame_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(OUT_WORDS - 1);
  localparam logic [TMO_W-1:0] LAST_TICK = TMO_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic [1:0]       bank_full_reg;
  logic [1:0]       bank_full_next;
  logic             cam_bank_reg;
  logic             rd_bank_reg;
  logic             rs_ena_reg;
  logic             busy_reg;
  logic             frame_done_reg;
  logic             tmo_err_reg;
  logic [7:0]       drop_cnt_reg;
  logic [CNT_W-1:0] wcnt_reg;
  logic [TMO_W-1:0] tcnt_reg;

  logic cam_ready;
  logic set_full;
  logic clr_full;
  logic last_word;
  logic tmo_hit;

  // The camera may not target a bank that still holds an unread frame or is being read.
  assign cam_ready = ~bank_full_reg[cam_bank_reg] & ~(busy_reg & (rd_bank_reg == cam_bank_reg));

  assign set_full  = bus.cam_frame_done & cam_ready;
  assign last_word = bus.rs_wr_en & (wcnt_reg == LAST_WORD);
  assign tmo_hit   = (tcnt_reg == LAST_TICK);
  assign clr_full  = (state_reg == RUN) & (last_word | tmo_hit);

  // Fill and release never hit the same bank: a fill needs that bank to be out of use.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_full_next[gi] = (set_full && cam_bank_reg == 1'(gi)) ? 1'b1 :
                                (clr_full && rd_bank_reg == 1'(gi))  ? 1'b0 :
                                bank_full_reg[gi];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      bank_full_reg  <= 2'b00;
      cam_bank_reg   <= 1'b0;
      rd_bank_reg    <= 1'b0;
      rs_ena_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      tmo_err_reg    <= 1'b0;
      drop_cnt_reg   <= 8'd0;
      wcnt_reg       <= '0;
      tcnt_reg       <= '0;
    end else begin
      bank_full_reg  <= bank_full_next;
      rs_ena_reg     <= 1'b0;
      frame_done_reg <= 1'b0;

      if (set_full) begin
        cam_bank_reg <= ~cam_bank_reg;
      end else if (bus.cam_frame_done && drop_cnt_reg != 8'hFF) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end

      case (state_reg)
        IDLE: begin
          if (bus.sched_en && |bank_full_reg) begin
            state_reg   <= START;
            // Oldest full bank: the one the camera would otherwise overwrite next.
            rd_bank_reg <= bank_full_reg[cam_bank_reg] ? cam_bank_reg : ~cam_bank_reg;
            wcnt_reg    <= '0;
            tcnt_reg    <= '0;
            rs_ena_reg  <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        START: begin
          state_reg <= RUN;
        end
        RUN: begin
          wcnt_reg <= wcnt_reg + CNT_W'(bus.rs_wr_en);
          tcnt_reg <= tcnt_reg + TMO_W'(1);
          if (last_word) begin
            state_reg      <= DONE;
            frame_done_reg <= 1'b1;
            busy_reg       <= 1'b0;
          end else if (tmo_hit) begin
            state_reg   <= DONE;
            tmo_err_reg <= 1'b1;
            busy_reg    <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.cam_bank   = cam_bank_reg;
  assign bus.cam_ready  = cam_ready;
  assign bus.rs_ena     = rs_ena_reg;
  assign bus.rd_bank    = rd_bank_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.tmo_err    = tmo_err_reg;
  assign bus.drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_flow_frame_sched.sv
// Scenario bench for flow_frame_sched with scaled-down frame size and watchdog limit;
// expected read banks are queued when frames are filled and popped at each reshaper start.
module tb_flow_frame_sched;

  localparam int OW = 20;
  localparam int CW = 5;
  localparam int TO = 50;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  flow_frame_sched_if bus();

  flow_frame_sched #(
    .OUT_WORDS(OW),
    .CNT_W(CW),
    .TIMEOUT(TO),
    .TMO_W(TW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit exp_bank_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    bus.cam_frame_done = 1'b1;
    tick();
    bus.cam_frame_done = 1'b0;
  endtask

  task automatic do_reset();
    bus.sched_en = 1'b0;
    bus.cam_frame_done = 1'b0;
    bus.rs_wr_en = 1'b0;
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    exp_bank_q.delete();
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.rs_ena === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pop_exp(output bit b, output bit ok);
    ok = (exp_bank_q.size() != 0);
    b = ok ? exp_bank_q.pop_front() : 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({bus.rs_ena, bus.busy, bus.frame_done, bus.tmo_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {bus.rs_ena, bus.busy, bus.frame_done, bus.tmo_err});
    end
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop got %0d exp 0", bus.drop_cnt);
    end
    checks++;
    if ({bus.cam_ready, bus.cam_bank, bus.rd_bank} !== 3'b100) begin
      errors++;
      $display("FAIL reset_banks got %b exp 100", {bus.cam_ready, bus.cam_bank, bus.rd_bank});
    end
    $display("txn reset: outputs checked");
  endtask

  task automatic test_start();
    bit b, ok;
    rstn = 1'b1;
    tick();
    bus.sched_en = 1'b1;
    bus.cam_frame_done = 1'b1;
    exp_bank_q.push_back(1'b0);
    tick();
    bus.cam_frame_done = 1'b0;
    checks++;
    if (bus.cam_bank !== 1'b1 || bus.rs_ena !== 1'b0) begin
      errors++;
      $display("FAIL start_t1 got cam_bank=%b rs_ena=%b exp 1 0", bus.cam_bank, bus.rs_ena);
    end
    tick();
    checks++;
    if (bus.rs_ena !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_t2 got rs_ena=%b busy=%b exp 1 1", bus.rs_ena, bus.busy);
    end
    pop_exp(b, ok);
    checks++;
    if (!ok || bus.rd_bank !== b) begin
      errors++;
      $display("FAIL start_rd_bank got %b exp %b (queued %0d)", bus.rd_bank, b, ok);
    end
    tick();
    checks++;
    if (bus.rs_ena !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse_width got rs_ena=%b busy=%b exp 0 1", bus.rs_ena, bus.busy);
    end
    $display("txn start: rd_bank=%b busy=%b", bus.rd_bank, bus.busy);
  endtask

  task automatic test_frame_done();
    int early;
    int restarts;
    early = 0;
    restarts = 0;
    bus.rs_wr_en = 1'b1;
    for (int i = 0; i < OW; i++) begin
      if (bus.frame_done === 1'b1) early++;
      tick();
    end
    checks++;
    if (early != 0 || bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_done got done=%b busy=%b early=%0d exp 1 0 0", bus.frame_done, bus.busy, early);
    end
    tick();
    bus.rs_wr_en = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse got %b exp 0", bus.frame_done);
    end
    repeat (6) begin
      tick();
      if (bus.rs_ena === 1'b1 || bus.busy === 1'b1) restarts++;
    end
    checks++;
    if (restarts != 0) begin
      errors++;
      $display("FAIL bank0_released got %0d restart cycles exp 0", restarts);
    end
    $display("txn frame_done: %0d strobes, bank released", OW);
  endtask

  task automatic test_drop();
    bit seen, b, ok;
    do_reset();
    bus.sched_en = 1'b1;
    exp_bank_q.push_back(1'b0);
    fill();
    wait_start(10, seen);
    pop_exp(b, ok);
    checks++;
    if (!seen || !ok || bus.rd_bank !== b) begin
      errors++;
      $display("FAIL drop_start got seen=%b rd_bank=%b exp 1 %b", seen, bus.rd_bank, b);
    end
    tick();
    checks++;
    if (bus.cam_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready_b1 got %b exp 1", bus.cam_ready);
    end
    exp_bank_q.push_back(1'b1);
    fill();
    checks++;
    if (bus.cam_bank !== 1'b0 || bus.cam_ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_fill_b1 got cam_bank=%b cam_ready=%b exp 0 0", bus.cam_bank, bus.cam_ready);
    end
    fill();
    checks++;
    if (bus.drop_cnt !== 8'd1 || bus.cam_bank !== 1'b0) begin
      errors++;
      $display("FAIL drop_first got drop_cnt=%0d cam_bank=%b exp 1 0", bus.drop_cnt, bus.cam_bank);
    end
    // Camera completes in the same cycle the reading bank is released: still a drop.
    for (int i = 0; i < OW; i++) begin
      bus.rs_wr_en = 1'b1;
      bus.cam_frame_done = (i == OW - 1);
      tick();
    end
    bus.rs_wr_en = 1'b0;
    bus.cam_frame_done = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b1 || bus.drop_cnt !== 8'd2 || bus.cam_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_simul got done=%b drop_cnt=%0d cam_ready=%b exp 1 2 1",
               bus.frame_done, bus.drop_cnt, bus.cam_ready);
    end
    tick();
    checks++;
    if (bus.rs_ena !== 1'b0) begin
      errors++;
      $display("FAIL drop_gap got rs_ena=%b exp 0", bus.rs_ena);
    end
    tick();
    pop_exp(b, ok);
    checks++;
    if (bus.rs_ena !== 1'b1 || !ok || bus.rd_bank !== b) begin
      errors++;
      $display("FAIL drop_next_start got rs_ena=%b rd_bank=%b exp 1 %b", bus.rs_ena, bus.rd_bank, b);
    end
    tick();
    bus.rs_wr_en = 1'b1;
    repeat (OW) tick();
    bus.rs_wr_en = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL drop_second_frame got %b exp 1", bus.frame_done);
    end
    $display("txn drop: drop_cnt=%0d", bus.drop_cnt);
  endtask

  task automatic test_both_full();
    bit seen, b, ok;
    int early;
    int starts;
    do_reset();
    bus.rs_wr_en = 1'b1;
    exp_bank_q.push_back(1'b0);
    fill();
    exp_bank_q.push_back(1'b1);
    fill();
    tick();
    checks++;
    if (bus.cam_bank !== 1'b0 || bus.cam_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rs_ena !== 1'b0) begin
      errors++;
      $display("FAIL both_full_idle got cam_bank=%b ready=%b busy=%b rs_ena=%b exp 0 0 0 0",
               bus.cam_bank, bus.cam_ready, bus.busy, bus.rs_ena);
    end
    bus.sched_en = 1'b1;
    wait_start(10, seen);
    pop_exp(b, ok);
    checks++;
    if (!seen || !ok || bus.rd_bank !== b) begin
      errors++;
      $display("FAIL both_first got seen=%b rd_bank=%b exp 1 %b", seen, bus.rd_bank, b);
    end
    // Strobes held high since IDLE: only RUN cycles may count.
    early = 0;
    tick();
    repeat (OW - 1) begin
      tick();
      if (bus.frame_done === 1'b1) early++;
    end
    tick();
    checks++;
    if (early != 0 || bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL both_first_done got done=%b early=%0d exp 1 0", bus.frame_done, early);
    end
    wait_start(10, seen);
    pop_exp(b, ok);
    checks++;
    if (!seen || !ok || bus.rd_bank !== b) begin
      errors++;
      $display("FAIL both_second got seen=%b rd_bank=%b exp 1 %b", seen, bus.rd_bank, b);
    end
    bus.sched_en = 1'b0;
    tick();
    repeat (OW) tick();
    bus.rs_wr_en = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL both_en_low_completes got %b exp 1", bus.frame_done);
    end
    fill();
    starts = 0;
    repeat (6) begin
      tick();
      if (bus.rs_ena === 1'b1) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL both_en_low_hold got %0d starts exp 0", starts);
    end
    exp_bank_q.push_back(1'b0);
    bus.sched_en = 1'b1;
    wait_start(10, seen);
    pop_exp(b, ok);
    checks++;
    if (!seen || !ok || bus.rd_bank !== b) begin
      errors++;
      $display("FAIL both_resume got seen=%b rd_bank=%b exp 1 %b", seen, bus.rd_bank, b);
    end
    $display("txn both_full: banks served in order 0,1,0");
  endtask

  task automatic test_timeout();
    bit seen, b, ok;
    int dones;
    do_reset();
    bus.sched_en = 1'b1;
    exp_bank_q.push_back(1'b0);
    fill();
    wait_start(10, seen);
    pop_exp(b, ok);
    checks++;
    if (!seen || !ok || bus.rd_bank !== b) begin
      errors++;
      $display("FAIL tmo_start got seen=%b rd_bank=%b exp 1 %b", seen, bus.rd_bank, b);
    end
    dones = 0;
    tick();
    repeat (TO - 1) begin
      tick();
      if (bus.frame_done === 1'b1) dones++;
    end
    checks++;
    if (bus.tmo_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got tmo_err=%b busy=%b exp 0 1", bus.tmo_err, bus.busy);
    end
    tick();
    checks++;
    if (bus.tmo_err !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || dones != 0) begin
      errors++;
      $display("FAIL tmo_abort got tmo_err=%b busy=%b done=%b dones=%0d exp 1 0 0 0",
               bus.tmo_err, bus.busy, bus.frame_done, dones);
    end
    tick();
    // Bank 0 must be free again, so the next full bank served is bank 1.
    exp_bank_q.push_back(1'b1);
    fill();
    wait_start(10, seen);
    pop_exp(b, ok);
    checks++;
    if (!seen || !ok || bus.rd_bank !== b || bus.tmo_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_release got seen=%b rd_bank=%b tmo_err=%b exp 1 %b 1", seen, bus.rd_bank, bus.tmo_err, b);
    end
    $display("txn timeout: tmo_err=%b after %0d run cycles", bus.tmo_err, TO);
  endtask

  task automatic test_async_reset();
    bit seen, b, ok;
    tick();
    fill();
    fill();
    bus.rs_wr_en = 1'b1;
    repeat (10) tick();
    bus.rs_wr_en = 1'b0;
    checks++;
    if (bus.drop_cnt !== 8'd1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got drop_cnt=%0d busy=%b exp 1 1", bus.drop_cnt, bus.busy);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.rs_ena, bus.busy, bus.frame_done, bus.tmo_err, bus.cam_ready, bus.cam_bank, bus.rd_bank} !== 7'b0000100
        || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL areset_now got flags=%b drop_cnt=%0d exp 0000100 0",
               {bus.rs_ena, bus.busy, bus.frame_done, bus.tmo_err, bus.cam_ready, bus.cam_bank, bus.rd_bank},
               bus.drop_cnt);
    end
    rstn = 1'b1;
    exp_bank_q.delete();
    tick();
    exp_bank_q.push_back(1'b0);
    fill();
    wait_start(10, seen);
    pop_exp(b, ok);
    checks++;
    if (!seen || !ok || bus.rd_bank !== b) begin
      errors++;
      $display("FAIL areset_restart got seen=%b rd_bank=%b exp 1 %b", seen, bus.rd_bank, b);
    end
    tick();
    bus.rs_wr_en = 1'b1;
    repeat (OW) tick();
    bus.rs_wr_en = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL areset_frame got %b exp 1", bus.frame_done);
    end
    $display("txn async_reset: restart frame completed=%b", bus.frame_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.sched_en = 1'b0;
    bus.cam_frame_done = 1'b0;
    bus.rs_wr_en = 1'b0;
    test_reset();
    test_start();
    test_frame_done();
    test_drop();
    test_both_full();
    test_timeout();
    test_async_reset();
    checks++;
    if (exp_bank_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_bank_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
